// File: rtl/m_dm_master.sv
// M-stage load/store initiator: issues one memory op over req/ready + rvalid, stalls the
// pipeline until completion and returns extended load data or an error.
module m_dm_master #(
    parameter int unsigned DM_WORDS = 3072,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_pc,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [1:0]  m_size,
    input  logic        m_unsigned,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic [31:0] m_rdata,
    output logic        m_done,
    output logic        m_err,
    output logic        m_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StDone} state_t;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic [31:0] r_pc;
    logic [31:0] r_cnt;

    logic        w_illegal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    always_comb begin
        w_illegal = (m_size == 2'b11)
                 || (m_size == 2'b01 && m_addr[0])
                 || (m_size == 2'b00 && m_addr[1:0] != 2'b00)
                 || ({2'b00, m_addr[31:2]} >= DM_WORDS);
        w_be    = 4'b1111;
        w_wdata = m_wdata;
        case (m_size)
            2'b10: begin
                w_be    = 4'b0001 << m_addr[1:0];
                w_wdata = {4{m_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = m_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{m_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction uses the offset/size latched when the op left IDLE.
    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
        case (r_size)
            2'b10:   w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    assign m_stall = m_req & (r_state != StDone) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_we      <= 1'b0;
            r_size    <= 2'b00;
            r_uns     <= 1'b0;
            r_off     <= 2'b00;
            r_pc      <= 32'h0;
            r_cnt     <= 32'h0;
            m_rdata   <= 32'h0;
            m_done    <= 1'b0;
            m_err     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (m_req) begin
                        r_we   <= m_we;
                        r_size <= m_size;
                        r_uns  <= m_unsigned;
                        r_off  <= m_addr[1:0];
                        r_pc   <= m_pc;
                        if (w_illegal) begin
                            r_state <= StDone;
                            m_done  <= 1'b1;
                            m_err   <= 1'b1;
                        end else begin
                            r_state   <= StIssue;
                            mem_req   <= 1'b1;
                            mem_we    <= m_we;
                            mem_addr  <= {m_addr[31:2], 2'b00};
                            mem_be    <= m_we ? w_be : 4'b1111;
                            mem_wdata <= m_we ? w_wdata : 32'h0;
                        end
                    end
                end
                StIssue: begin
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_be    <= 4'h0;
                        mem_wdata <= 32'h0;
                        if (r_we) begin
                            r_state <= StDone;
                            m_done  <= 1'b1;
                        end else if (mem_rvalid) begin
                            r_state <= StDone;
                            m_done  <= 1'b1;
                            m_rdata <= w_ext;
                        end else begin
                            r_state <= StWaitRsp;
                            r_cnt   <= 32'h0;
                        end
                    end
                end
                StWaitRsp: begin
                    // r_cnt counts WAIT_RSP cycles already spent; rvalid wins over timeout.
                    if (mem_rvalid) begin
                        r_state <= StDone;
                        m_done  <= 1'b1;
                        m_rdata <= w_ext;
                    end else if (r_cnt + 32'd1 == TIMEOUT) begin
                        r_state <= StDone;
                        m_done  <= 1'b1;
                        m_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    m_done  <= 1'b0;
                    m_err   <= 1'b0;
                    m_rdata <= 32'h0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifndef SYNTHESIS
    logic [31:0] w_mask;
    assign w_mask = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};

    always_ff @(posedge clk) begin
        if (!reset && r_state == StIssue && mem_ready && r_we) begin
            $display("%d@%h: *%h <= %h", $time, r_pc, mem_addr, mem_wdata & w_mask);
        end
    end
`endif

endmodule

// File: tb/tb_m_dm_master.sv
// Randomised bench for m_dm_master: a transaction-level model predicts latency, lanes,
// errors and load data for each op, and a cycle loop compares the DUT against it.
module tb_m_dm_master;

    localparam int unsigned TMO   = 4;
    localparam int unsigned WORDS = 3072;

    logic        clk;
    logic        reset;
    logic [31:0] m_pc;
    logic        m_req;
    logic        m_we;
    logic [1:0]  m_size;
    logic        m_unsigned;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_done;
    logic        m_err;
    logic        m_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks;
    int n_fails;

    m_dm_master #(
        .DM_WORDS (WORDS),
        .TIMEOUT  (TMO)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .m_pc       (m_pc),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_size     (m_size),
        .m_unsigned (m_unsigned),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_done     (m_done),
        .m_err      (m_err),
        .m_stall    (m_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] w);
        logic [31:0] v;
        if (size == 2'd2) begin
            v = (w >> (8 * off)) & 32'hff;
            if (!uns && v[7]) v = v | 32'hffffff00;
        end else if (size == 2'd1) begin
            v = (w >> (16 * (off / 2))) & 32'hffff;
            if (!uns && v[15]) v = v | 32'hffff0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Drives one op and plays the responder: ready after dr ISSUE cycles, rvalid dv cycles
    // after acceptance (dv=0 means together with ready).
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rword, input int dr, input int dv);
        logic        illegal;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          lat;
        int          iss;
        int          acc;
        logic [1:0]  off;

        off     = addr[1:0];
        illegal = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd0 && off != 0)
               || ((addr >> 2) >= WORDS);
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        exp_be    = 4'hf;
        exp_wd    = 32'h0;
        if (we) begin
            exp_wd = wdata;
            if (size == 2'd2) begin
                exp_be = 4'(1 << off);
                exp_wd = (wdata & 32'hff) * 32'h01010101;
            end else if (size == 2'd1) begin
                exp_be = 4'(3 << (off & 2'd2));
                exp_wd = (wdata & 32'hffff) * 32'h00010001;
            end
        end
        if (illegal) begin
            lat = 1; exp_err = 1'b1;
        end else if (we) begin
            lat = 2 + dr;
        end else if (dv <= int'(TMO)) begin
            lat = 2 + dr + dv; exp_rdata = ext_load(size, uns, off, rword);
        end else begin
            lat = 2 + dr + int'(TMO); exp_err = 1'b1;
        end

        iss = 0;
        acc = -1;
        for (int c = 0; c <= lat + 1; c++) begin
            @(posedge clk);
            #1;
            check("ctl{req,done,err}", {29'h0, mem_req, m_done, m_err},
                  {29'h0, !illegal && c >= 1 && c <= 1 + dr, c == lat, c == lat && exp_err});
            if (c == lat || c == lat + 1) check("m_rdata", m_rdata, (c == lat) ? exp_rdata : 0);
            if (c == 1 && !illegal) begin
                check("mem_addr", mem_addr, addr & 32'hfffffffc);
                check("mem_we", {31'h0, mem_we}, {31'h0, we});
                check("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
                if (we) check("mem_wdata", mem_wdata, exp_wd);
            end
            m_req = (c < lat);
            if (c == 0) begin
                m_we = we; m_size = size; m_unsigned = uns; m_addr = addr; m_wdata = wdata;
                m_pc = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
            end else begin
                m_we = 1'($urandom); m_size = 2'($urandom); m_unsigned = 1'($urandom);
                m_addr = $urandom; m_wdata = $urandom; m_pc = $urandom;
            end
            mem_ready = mem_req && (iss == dr);
            if (mem_ready && !mem_we) acc = c;
            if (mem_req) iss++;
            mem_rvalid = (acc >= 0) && (c == acc + dv);
            mem_rdata  = mem_rvalid ? rword : $urandom;
            #1;
            check("m_stall", {31'h0, m_stall}, {31'h0, c < lat});
        end
    endtask

    initial begin
        logic [31:0] widx;
        logic [1:0]  sz;
        logic [1:0]  o;

        n_checks = 0;
        n_fails  = 0;
        m_pc = 0; m_req = 0; m_we = 0; m_size = 0; m_unsigned = 0; m_addr = 0; m_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {m_rdata ^ mem_addr ^ mem_wdata},
              32'h0);
        check("reset ctl", {23'h0, m_done, m_err, m_stall, mem_req, mem_we, mem_be}, 32'h0);
        reset = 1'b0;

        run_op(1'b1, 2'd0, 1'b0, 32'h10, 32'hdeadbeef, 32'h0, 0, 0);
        run_op(1'b1, 2'd2, 1'b0, 32'h13, 32'h000000ab, 32'h0, 0, 0);
        run_op(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'h80ff7f01, 0, 1);
        run_op(1'b0, 2'd2, 1'b1, 32'h12, 32'h0, 32'h80ff7f01, 0, 1);
        run_op(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 0, 1);
        run_op(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 32'h12345678, 5, 3);
        run_op(1'b0, 2'd0, 1'b0, 32'h44, 32'h0, 32'h0, 0, 99);
        run_op(1'b0, 2'd1, 1'b0, 32'h46, 32'h0, 32'h8001abcd, 1, 0);
        run_op(1'b0, 2'd0, 1'b0, WORDS * 4, 32'h0, 32'h0, 0, 1);
        run_op(1'b1, 2'd0, 1'b0, WORDS * 4 - 4, 32'h55aa55aa, 32'h0, 2, 0);
        run_op(1'b1, 2'd3, 1'b0, 32'h20, 32'h1, 32'h0, 0, 0);

        // Reset in the middle of WAIT_RSP, then a normal op.
        @(posedge clk); #1;
        m_req = 1; m_we = 0; m_size = 0; m_addr = 32'h80;
        @(posedge clk); #1;
        mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0;
        @(posedge clk); #1;
        check("stall before reset", {31'h0, m_stall}, 32'h1);
        reset = 1'b1;
        #1;
        check("reset mid-op data", m_rdata | mem_addr | mem_wdata, 32'h0);
        check("reset mid-op ctl", {23'h0, m_done, m_err, m_stall, mem_req, mem_we, mem_be}, 32'h0);
        m_req = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(1'b0, 2'd2, 1'b1, 32'h83, 32'h0, 32'hc0ffee11, 0, 1);

        for (int i = 0; i < 150; i++) begin
            sz   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            widx = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(WORDS, WORDS + 100))
                                               : 32'($urandom_range(0, WORDS - 1));
            if ($urandom_range(0, 3) == 0) o = 2'($urandom);
            else if (sz == 2'd2)           o = 2'($urandom);
            else if (sz == 2'd1)           o = {1'($urandom), 1'b0};
            else                           o = 2'd0;
            run_op(1'($urandom), sz, 1'($urandom), {widx[29:0], o}, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
